ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/cpu_pkg.sv | 11 +
 rtl/fetch_queue.sv | 65 ++++++
 rtl/ifetch.sv | 78 +++++++
 tb/tb_ifetch.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants used by fetch and decode.
// Holds default widths and the HALT opcode.
package cpu_pkg;
   localparam int CPU_AW = 8;
   localparam int CPU_IW = 16;
   localparam logic [3:0] OP_HALT = 4'b1111;

   function automatic logic is_halt(input logic [3:0] op);
      return op == OP_HALT;
   endfunction
endpackage

// File: rtl/fetch_queue.sv
// Small prefetch FIFO with flush.
// Head entry is read combinationally.
module fetch_queue #(
   parameter int W     = 24,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wp_q, wp_d;
   logic [PW-1:0] rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      mem_d = mem_q;
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (flush) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
      end else begin
         if (wr_en) begin
            mem_d[wp_q] = wr_data;
            wp_d        = wp_q + 1'b1;
         end
         if (rd_en) begin
            rp_d = rp_q + 1'b1;
         end
         cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
      end
   end

   // Storage is cleared so the head reads as zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   assign rd_data = mem_q[rp_q];
   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC, HALT and redirect control
// in front of a small prefetch queue.
module ifetch
   import cpu_pkg::*;
#(
   parameter int AW    = CPU_AW,
   parameter int IW    = CPU_IW,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   output logic [AW-1:0] imem_addr,
   input  logic [IW-1:0] imem_rdata,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_pc,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] out_instr,
   output logic [AW-1:0] out_pc,
   output logic          halted
);
   logic [AW-1:0]    fpc_q, fpc_d;
   logic             halted_q, halted_d;
   logic             do_fetch;
   logic             deq;
   logic             word_halt;
   logic             q_full;
   logic             q_empty;
   logic [IW+AW-1:0] q_rdata;

   assign word_halt = is_halt(imem_rdata[IW-1 -: 4]);
   assign out_valid = !q_empty && !redirect_valid;
   assign deq       = out_valid && out_ready;
   assign do_fetch  = !halted_q && !redirect_valid && (!q_full || deq);

   // HALT is enqueued but fpc stays on it.
   always_comb begin
      fpc_d    = fpc_q;
      halted_d = halted_q;
      if (redirect_valid) begin
         fpc_d    = redirect_pc;
         halted_d = 1'b0;
      end else if (do_fetch) begin
         if (word_halt) halted_d = 1'b1;
         else           fpc_d    = fpc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fpc_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         fpc_q    <= fpc_d;
         halted_q <= halted_d;
      end
   end

   fetch_queue #(
      .W     (IW + AW),
      .DEPTH (DEPTH)
   ) u_q (
      .clk     (clk),
      .rst_n   (rst),
      .flush   (redirect_valid),
      .wr_en   (do_fetch),
      .wr_data ({imem_rdata, fpc_q}),
      .rd_en   (deq),
      .rd_data (q_rdata),
      .full    (q_full),
      .empty   (q_empty)
   );

   assign imem_addr = fpc_q;
   assign out_instr = q_rdata[IW+AW-1:AW];
   assign out_pc    = q_rdata[AW-1:0];
   assign halted    = halted_q;
endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a delivery scoreboard.
// Expected fetches are queued, then matched on handshakes.
module tb_ifetch;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_instr;
   logic [7:0]  out_pc;
   logic        halted;

   logic [15:0] mem [256];
   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0]  pc;
      logic [15:0] ins;
   } ent_t;
   ent_t sb[$];

   always #5 clk = ~clk;
   assign imem_rdata = mem[imem_addr];

   ifetch dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .halted         (halted)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_pc(input logic [7:0] pc);
      ent_t e;
      e.pc  = pc;
      e.ins = mem[pc];
      sb.push_back(e);
   endtask

   // One cycle: match any handshake at the negedge, then pass the edge.
   task automatic tick();
      ent_t e;
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         tests++;
         assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL unexpected obs_pc=%0h exp=none", out_pc);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("deliv_pc", out_pc, e.pc);
            chk("deliv_ins", out_instr, e.ins);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [7:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      @(negedge clk);
      chk("redir_valid_low", out_valid, 0);
      tick();
      redirect_valid = 1'b0;
      sb.delete();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
      mem[0]    = 16'h1123;
      mem[1]    = 16'h2455;
      mem[2]    = 16'hF000;
      mem[8'h31] = 16'hF000;
      rst            = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_instr", out_instr, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_halted", halted, 0);

      // Backpressure from reset: queue fills with 0,1 and holds at 2.
      @(negedge clk);
      rst = 1'b1;
      expect_pc(0);
      expect_pc(1);
      expect_pc(2);
      repeat (5) tick();
      chk("bp_addr", imem_addr, 2);
      chk("bp_pc", out_pc, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_halted", halted, 0);
      out_ready = 1'b1;
      repeat (5) tick();
      chk("bp_drained", sb.size(), 0);
      chk("halt_flag", halted, 1);
      chk("halt_valid", out_valid, 0);
      chk("halt_addr", imem_addr, 2);

      // Full queue with a steady consumer.
      out_ready = 1'b0;
      redirect(8'h10);
      tick();
      tick();
      chk("full_addr", imem_addr, 8'h12);
      for (int i = 0; i < 6; i++) expect_pc(8'(8'h10 + i));
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("full_addr_step", imem_addr, 8'h13 + i);
         chk("full_valid", out_valid, 1);
      end
      chk("full_delivered", sb.size(), 2);

      // Redirect while full and halted.
      out_ready = 1'b0;
      redirect(8'h30);
      repeat (3) tick();
      chk("pre_halted", halted, 1);
      chk("pre_addr", imem_addr, 8'h31);
      chk("pre_valid", out_valid, 1);
      redirect(8'h40);
      chk("post_halted", halted, 0);
      chk("post_addr", imem_addr, 8'h40);
      chk("post_valid", out_valid, 0);
      expect_pc(8'h40);
      expect_pc(8'h41);
      expect_pc(8'h42);
      out_ready = 1'b1;
      repeat (4) tick();
      chk("post_drained", sb.size(), 0);

      // Address wrap through 0 into the HALT at 2.
      redirect(8'hFE);
      expect_pc(8'hFE);
      expect_pc(8'hFF);
      expect_pc(8'h00);
      expect_pc(8'h01);
      expect_pc(8'h02);
      repeat (8) tick();
      chk("wrap_drained", sb.size(), 0);
      chk("wrap_halted", halted, 1);

      // Asynchronous reset with a full queue.
      out_ready = 1'b0;
      redirect(8'h50);
      repeat (3) tick();
      chk("ar_pre_valid", out_valid, 1);
      chk("ar_pre_pc", out_pc, 8'h50);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_pc", out_pc, 0);
      chk("ar_addr", imem_addr, 0);
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b1;
      expect_pc(0);
      expect_pc(1);
      expect_pc(2);
      repeat (5) tick();
      chk("ar_drained", sb.size(), 0);
      chk("ar_halted", halted, 1);
      chk("ar_hold_addr", imem_addr, 2);
      chk("ar_end_valid", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
